bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter built on the shift-and-add-3 (double-dabble) algorithm. It converts a W-bit unsigned binary word into DIGITS packed BCD digits, one bit per clock. Valid/ready handshakes on both sides let it sit between a binary datapath (counters, ALU results) and the seven-segment/display drivers. It generalises the team's fixed 4-bit combinational code converters to arbitrary width.

## Interface
- W, default 8: input binary width, 1..32.
- DIGITS, default 3: number of output BCD digits. Elaboration must fail via a generate-time error if 10^DIGITS < 2^W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bin is presented.
- in_ready  out  1  block can accept a word. High only in IDLE and while rst is low.
- in_bin  in  W  unsigned binary operand, sampled on the accept edge.
- out_valid  out  1  out_bcd holds a completed result.
- out_ready  in  1  consumer takes the result.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- busy  out  1  high in SHIFT state.

## Operation
- State machine has three states.
  - IDLE: in_ready=1. On in_valid=1:
    - load bin shift register <= in_bin.
    - clear the BCD accumulator.
    - load bit counter <= W.
    - go to SHIFT.
  - SHIFT: each cycle, every 4-bit digit of the accumulator that is >=5 gets +3 (all digits corrected in parallel, before the shift). Then {accumulator, bin} shifts left by 1 and the counter decrements. When the counter reaches 1 on this edge (the last bit shifted), go to DONE.
  - DONE: out_valid=1 and out_bcd is stable. On out_ready=1, go to IDLE.
- Inputs are ignored outside IDLE. in_valid asserted while busy is neither queued nor flagged.
- out_bcd holds its last value in IDLE and SHIFT. It is updated only on the SHIFT->DONE edge; the intermediate accumulator is internal.
- Arithmetic: digit correction is a 4-bit add with no carry-out, valid because digit<=9 holds before correction. No overflow is possible, given the parameter check.

## Timing
- Reset values: state=IDLE, out_valid=0, busy=0, out_bcd=0, counter=0. in_ready=0 while rst is high and 1 on the first cycle after release.
- Reset mid-operation, in any state, aborts immediately and asynchronously. The in-flight result is discarded and out_valid drops in the same cycle.
- Latency: accept at edge k; busy high after edges k..k+W-1; out_valid=1 after edge k+W.
- Throughput: with out_ready held high, one word per W+2 cycles (accept edge + W shift edges + handoff edge). in_ready rises the cycle after the handoff edge.
- Handshakes: transfer occurs when valid&&ready at a rising edge. out_valid, once high, stays high with out_bcd constant until the transfer edge.
- Simultaneous events:
  - out_ready high on the same edge out_valid first rises has no effect. The transfer needs out_valid already high at that edge.
  - in_valid in DONE is ignored.
- W=1 degenerate case: a single SHIFT cycle, latency 1.

## Test plan
- W=8, DIGITS=3: accept in_bin=255, out_ready=1 → out_valid exactly 8 edges after accept, out_bcd=12'h255, busy high for 8 cycles.
- Boundary values:
  - W=8, in_bin=0 → out_bcd=12'h000.
  - in_bin=9 → 12'h009.
  - in_bin=10 → 12'h010.
  - in_bin=99 → 12'h099.
  - in_bin=100 → 12'h100.
- Backpressure: in_bin=173 with out_ready=0 for 5 cycles after out_valid → out_bcd=12'h173 stable, in_ready=0 throughout. Raising out_ready gives one transfer, then in_ready=1 the next cycle.
- in_valid pulsed with in_bin=42 at cycle 3 of a conversion of 200 → result 12'h200 only. No second out_valid without a new accept in IDLE.
- rst asserted at shift cycle 4 of in_bin=128 → out_valid=0 and out_bcd=0 immediately. After release, conversion of 7 → 12'h007 with nominal latency.
- W=16, DIGITS=5: in_bin=65535 → 20'h65535 after 16 edges. Back-to-back 1234 and 4321 with out_ready=1 → two results spaced 18 cycles apart.
- W=8, DIGITS=2 → elaboration error.

Source files
------------

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: valid/ready handshake bundle between a binary producer and a BCD consumer.
interface bin2bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  busy;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per clock, valid/ready on both sides.
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input logic      clk,
    input logic      rst,
    bin2bcd_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    function automatic bit fits();
        longint unsigned p = 1;
        for (int i = 0; i < DIGITS && p < (64'd1 << W); i++) p = p * 10;
        return p >= (64'd1 << W);
    endfunction

    generate
        if (W < 1 || W > 32 || DIGITS < 1 || !fits()) begin : g_bad_params
            $error("bin2bcd_seq: DIGITS too small (or W out of 1..32) for the binary width");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   bin_q, bin_d;
    logic [BW-1:0]  acc_q, acc_d, adj, shifted, bcd_q, bcd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        shifted = {adj[BW-2:0], bin_q[W-1]};
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = SHIFT;
                bin_d   = bus.in_bin;
                acc_d   = '0;
                cnt_d   = CW'(W);
            end
            SHIFT: begin
                acc_d = shifted;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - 1'b1;
                // The edge that shifts the last bit also publishes the result.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    bcd_d   = shifted;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE && !rst;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q == SHIFT;
    assign bus.out_bcd   = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq at W=8/DIGITS=3 and W=16/DIGITS=5
// against a decimal-digit reference computed with div/mod.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    bin2bcd_if #(.W(8),  .DIGITS(3)) b8();
    bin2bcd_if #(.W(16), .DIGITS(5)) b16();

    bin2bcd_seq #(.W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    bin2bcd_seq #(.W(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input int unsigned v, input int stall, input bit early, input string tag);
        int lat, nb;
        logic [11:0] held;
        chk({tag, "/in_ready_idle"}, 32'(b8.in_ready), 1);
        b8.in_valid  = 1'b1;
        b8.in_bin    = 8'(v);
        b8.out_ready = early;
        tick();
        b8.in_valid = 1'b0;
        lat = 0;
        nb  = 0;
        while (b8.out_valid !== 1'b1 && lat < 40) begin
            nb += int'(b8.busy);
            tick();
            lat++;
        end
        chk({tag, "/latency"}, lat, 8);
        chk({tag, "/busy_cycles"}, nb, 8);
        chk({tag, "/bcd"}, 32'(b8.out_bcd), ref_bcd(v, 3));
        chk({tag, "/busy_done"}, 32'(b8.busy), 0);
        held = b8.out_bcd;
        repeat (stall) begin
            tick();
            chk({tag, "/stall_valid"}, 32'(b8.out_valid), 1);
            chk({tag, "/stall_bcd"}, 32'(b8.out_bcd), 32'(held));
            chk({tag, "/stall_in_ready"}, 32'(b8.in_ready), 0);
        end
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        chk({tag, "/valid_after_xfer"}, 32'(b8.out_valid), 0);
        chk({tag, "/in_ready_after_xfer"}, 32'(b8.in_ready), 1);
    endtask

    task automatic run16(input int unsigned v, input string tag);
        int lat;
        b16.in_valid = 1'b1;
        b16.in_bin   = 16'(v);
        tick();
        b16.in_valid = 1'b0;
        lat = 0;
        while (b16.out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, "/latency"}, lat, 16);
        chk({tag, "/bcd"}, 32'(b16.out_bcd), ref_bcd(v, 5));
        b16.out_ready = 1'b1;
        tick();
        b16.out_ready = 1'b0;
        chk({tag, "/valid_after_xfer"}, 32'(b16.out_valid), 0);
    endtask

    initial begin
        int n, acc, t0;
        bit prev;
        int times[$];
        logic [19:0] vals[$];
        int unsigned bnd[5] = '{0, 9, 10, 99, 100};
        b8.in_valid = 0;  b8.in_bin = '0;  b8.out_ready = 0;
        b16.in_valid = 0; b16.in_bin = '0; b16.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/in_ready", 32'(b8.in_ready), 0);
        chk("rst/out_valid", 32'(b8.out_valid), 0);
        chk("rst/out_bcd", 32'(b8.out_bcd), 0);
        chk("rst/busy", 32'(b8.busy), 0);
        chk("rst/in_ready16", 32'(b16.in_ready), 0);
        rst = 1'b0;
        tick();
        chk("post_rst/in_ready", 32'(b8.in_ready), 1);

        run8(255, 0, 1'b1, "b255");
        chk("b255/literal", 32'(b8.out_bcd), 32'h255);
        foreach (bnd[i]) run8(bnd[i], 0, 1'b0, $sformatf("bnd%0d", bnd[i]));
        run8(173, 5, 1'b0, "bp173");

        // Second in_valid pulse lands mid-conversion and must vanish.
        b8.in_valid = 1'b1;
        b8.in_bin   = 8'd200;
        tick();
        b8.in_valid = 1'b0;
        tick();
        tick();
        b8.in_valid = 1'b1;
        b8.in_bin   = 8'd42;
        tick();
        b8.in_valid = 1'b0;
        n = 0;
        while (b8.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("pulse/latency", n + 3, 8);
        chk("pulse/bcd", 32'(b8.out_bcd), 32'h200);
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        n = 0;
        repeat (12) begin
            tick();
            n += int'(b8.out_valid);
        end
        chk("pulse/no_second_result", n, 0);

        // Asynchronous reset between clock edges during shifting.
        b8.in_valid = 1'b1;
        b8.in_bin   = 8'd128;
        tick();
        b8.in_valid = 1'b0;
        repeat (3) tick();
        chk("abort/busy_before", 32'(b8.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort/out_valid", 32'(b8.out_valid), 0);
        chk("abort/out_bcd", 32'(b8.out_bcd), 0);
        chk("abort/busy", 32'(b8.busy), 0);
        chk("abort/in_ready", 32'(b8.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run8(7, 0, 1'b0, "post_abort7");

        repeat (16) run8($urandom_range(0, 255), $urandom_range(0, 3), 1'b0, "rnd8");

        run16(65535, "w16_max");
        chk("w16_max/literal", 32'(b16.out_bcd), 32'h65535);
        repeat (4) run16($urandom_range(0, 65535), "rnd16");

        // Back-to-back words with out_ready held high.
        b16.out_ready = 1'b1;
        b16.in_valid  = 1'b1;
        b16.in_bin    = 16'd1234;
        acc  = 0;
        prev = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (b16.busy && !prev) begin
                acc++;
                if (acc == 1) b16.in_bin = 16'd4321;
                else b16.in_valid = 1'b0;
            end
            prev = b16.busy;
            if (b16.out_valid) begin
                times.push_back(t);
                vals.push_back(b16.out_bcd);
            end
        end
        b16.out_ready = 1'b0;
        b16.in_valid  = 1'b0;
        chk("b2b/results", times.size(), 2);
        if (times.size() == 2) begin
            t0 = times[1] - times[0];
            chk("b2b/spacing", t0, 18);
            chk("b2b/first", 32'(vals[0]), ref_bcd(1234, 5));
            chk("b2b/second", 32'(vals[1]), ref_bcd(4321, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end
endmodule
